// File: rtl/stream_parity_accumulator.sv
// Streaming frame parity accumulator: XOR-reduces each word, accumulates across an
// in_last-delimited frame and publishes parity, saturating word count and check error.
module stream_parity_accumulator #(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned CNT_W       = 8,
    parameter bit          ODD_DEFAULT = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic             in_odd,
    input  logic             in_chk_en,
    input  logic             in_chk,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_parity,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf,
    output logic             out_err
);

    typedef enum logic [0:0] {StIdle, StAccum} state_e;

    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    state_e           state_q, state_d;
    logic             acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             mode_q, mode_d;

    logic             valid_q, valid_d;
    logic             parity_q, parity_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             oovf_q, oovf_d;
    logic             err_q, err_d;

    logic             accept;
    logic             word_par;
    logic             acc_next;
    logic [CNT_W-1:0] cnt_next;
    logic             ovf_next;
    logic             mode_eff;
    logic             par_next;

    assign in_ready   = !valid_q || out_ready;
    assign accept     = in_valid && in_ready;
    assign word_par   = ^in_data;

    assign out_valid  = valid_q;
    assign out_parity = parity_q;
    assign out_count  = count_q;
    assign out_ovf    = oovf_q;
    assign out_err    = err_q;

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        mode_d   = mode_q;
        valid_d  = valid_q;
        parity_d = parity_q;
        count_d  = count_q;
        oovf_d   = oovf_q;
        err_d    = err_q;

        // First word of a frame starts from a clean accumulator and takes in_odd directly.
        if (state_q == StAccum) begin
            acc_next = acc_q ^ word_par;
            cnt_next = (cnt_q == CntMax) ? cnt_q : cnt_q + CNT_W'(1);
            ovf_next = ovf_q | (cnt_q == CntMax);
            mode_eff = mode_q;
        end else begin
            acc_next = word_par;
            cnt_next = CNT_W'(1);
            ovf_next = 1'b0;
            mode_eff = in_odd;
        end
        par_next = acc_next ^ mode_eff;

        if (accept) begin
            if (state_q == StIdle) begin
                mode_d = in_odd;
            end
            if (in_last) begin
                state_d  = StIdle;
                acc_d    = 1'b0;
                cnt_d    = '0;
                ovf_d    = 1'b0;
                valid_d  = 1'b1;
                parity_d = par_next;
                count_d  = cnt_next;
                oovf_d   = ovf_next;
                err_d    = in_chk_en & (par_next != in_chk);
            end else begin
                state_d = StAccum;
                acc_d   = acc_next;
                cnt_d   = cnt_next;
                ovf_d   = ovf_next;
                if (out_ready) begin
                    valid_d = 1'b0;
                end
            end
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            acc_q    <= 1'b0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            mode_q   <= ODD_DEFAULT;
            valid_q  <= 1'b0;
            parity_q <= 1'b0;
            count_q  <= '0;
            oovf_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            mode_q   <= mode_d;
            valid_q  <= valid_d;
            parity_q <= parity_d;
            count_q  <= count_d;
            oovf_q   <= oovf_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_stream_parity_accumulator.sv
// Randomised and directed bench for stream_parity_accumulator; two instances (CNT_W=8 and
// CNT_W=2) share stimulus and are checked against a frame-level reference model.
module tb_stream_parity_accumulator;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid, in_last, in_odd, in_chk_en, in_chk, out_ready;
    logic [3:0] in_data;

    logic       in_ready8, out_valid8, out_parity8, out_ovf8, out_err8;
    logic [7:0] out_count8;
    logic       in_ready2, out_valid2, out_parity2, out_ovf2, out_err2;
    logic [1:0] out_count2;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: words of the open frame, plus the last published result.
    bit q[$];
    bit m_mode;
    bit m_valid;
    bit m_par;
    int m_n;
    bit m_err;

    always #5 clk = ~clk;

    stream_parity_accumulator #(.WIDTH(4), .CNT_W(8), .ODD_DEFAULT(1'b0)) dut8 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready8),
        .in_data(in_data), .in_last(in_last), .in_odd(in_odd), .in_chk_en(in_chk_en),
        .in_chk(in_chk), .out_valid(out_valid8), .out_ready(out_ready),
        .out_parity(out_parity8), .out_count(out_count8), .out_ovf(out_ovf8),
        .out_err(out_err8)
    );

    stream_parity_accumulator #(.WIDTH(4), .CNT_W(2), .ODD_DEFAULT(1'b1)) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
        .in_data(in_data), .in_last(in_last), .in_odd(in_odd), .in_chk_en(in_chk_en),
        .in_chk(in_chk), .out_valid(out_valid2), .out_ready(out_ready),
        .out_parity(out_parity2), .out_count(out_count2), .out_ovf(out_ovf2),
        .out_err(out_err2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_zero();
        check("rst_valid8", 32'(out_valid8), 0);
        check("rst_par8", 32'(out_parity8), 0);
        check("rst_cnt8", 32'(out_count8), 0);
        check("rst_ovf8", 32'(out_ovf8), 0);
        check("rst_err8", 32'(out_err8), 0);
        check("rst_valid2", 32'(out_valid2), 0);
        check("rst_cnt2", 32'(out_count2), 0);
    endtask

    task automatic check_outputs();
        check("valid8", 32'(out_valid8), 32'(m_valid));
        check("valid2", 32'(out_valid2), 32'(m_valid));
        if (m_valid) begin
            check("par8", 32'(out_parity8), 32'(m_par));
            check("par2", 32'(out_parity2), 32'(m_par));
            check("cnt8", 32'(out_count8), (m_n > 255) ? 255 : m_n);
            check("ovf8", 32'(out_ovf8), 32'(m_n > 255));
            check("cnt2", 32'(out_count2), (m_n > 3) ? 3 : m_n);
            check("ovf2", 32'(out_ovf2), 32'(m_n > 3));
            check("err8", 32'(out_err8), 32'(m_err));
            check("err2", 32'(out_err2), 32'(m_err));
        end
    endtask

    // Drive one cycle from a negedge, advance the model at the posedge, check at the next negedge.
    task automatic cycle(input bit v, input logic [3:0] d, input bit last, input bit odd,
                         input bit chken, input bit chk, input bit ordy);
        bit acc;
        bit p;
        in_valid  = v;
        in_data   = d;
        in_last   = last;
        in_odd    = odd;
        in_chk_en = chken;
        in_chk    = chk;
        out_ready = ordy;
        #1;
        acc = v && (!m_valid || ordy);
        check("in_ready8", 32'(in_ready8), 32'(!m_valid || ordy));
        check("in_ready2", 32'(in_ready2), 32'(!m_valid || ordy));
        @(posedge clk);
        if (acc) begin
            if (q.size() == 0) m_mode = odd;
            q.push_back(($countones(d) % 2) == 1);
            if (last) begin
                p = m_mode;
                foreach (q[i]) p ^= q[i];
                m_par   = p;
                m_n     = q.size();
                m_err   = chken && (p != chk);
                m_valid = 1'b1;
                q.delete();
            end else if (ordy) begin
                m_valid = 1'b0;
            end
        end else if (ordy) begin
            m_valid = 1'b0;
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic model_reset();
        q.delete();
        m_valid = 1'b0;
        m_par   = 1'b0;
        m_n     = 0;
        m_err   = 1'b0;
    endtask

    initial begin
        logic [3:0] held_cnt;
        reset = 1'b1;
        in_valid = 0; in_data = 0; in_last = 0; in_odd = 0;
        in_chk_en = 0; in_chk = 0; out_ready = 0;
        model_reset();
        @(negedge clk);
        check_zero();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_zero();

        // Single word 4'h1, then all 16 values as 1-word frames.
        cycle(1, 4'h1, 1, 0, 0, 0, 1);
        check("first_par", 32'(out_parity8), 1);
        check("first_cnt", 32'(out_count8), 1);
        for (int i = 0; i < 16; i++) cycle(1, 4'(i), 1, 0, 0, 0, 1);

        // Odd frame with in_odd toggled mid-frame.
        cycle(1, 4'h3, 0, 1, 0, 0, 1);
        cycle(1, 4'h7, 0, 0, 0, 0, 1);
        cycle(1, 4'h1, 1, 0, 0, 0, 1);
        check("odd_par", 32'(out_parity8), 1);
        check("odd_cnt", 32'(out_count8), 3);

        // Check path.
        cycle(1, 4'hF, 1, 0, 1, 1, 1);
        check("chk_err1", 32'(out_err8), 1);
        cycle(1, 4'hF, 1, 0, 1, 0, 1);
        check("chk_err0", 32'(out_err8), 0);

        // Backpressure: pending result with out_ready low for 5 cycles.
        cycle(1, 4'hB, 1, 0, 0, 0, 0);
        held_cnt = 4'(out_count8);
        for (int i = 0; i < 5; i++) cycle(1, 4'h2, 1, 0, 0, 0, 0);
        check("bp_hold_cnt", 32'(out_count8), 32'(held_cnt));
        cycle(1, 4'h2, 1, 0, 0, 0, 1);
        check("bp_release_par", 32'(out_parity8), 1);
        for (int i = 0; i < 4; i++) cycle(1, 4'(i + 5), 1, 0, 0, 0, 1);
        cycle(0, 4'h0, 0, 0, 0, 0, 1);

        // Saturation on the CNT_W=2 instance.
        for (int i = 0; i < 5; i++) cycle(1, 4'h1, i == 4, 0, 0, 0, 1);
        check("sat_cnt2", 32'(out_count2), 3);
        check("sat_ovf2", 32'(out_ovf2), 1);
        check("sat_par2", 32'(out_parity2), 1);

        // Frame of exactly 255 words: no overflow on the 8-bit counter; then 257 words.
        for (int i = 0; i < 255; i++) cycle(1, 4'($urandom), i == 254, 0, 0, 0, 1);
        for (int i = 0; i < 257; i++) cycle(1, 4'($urandom), i == 256, 1, 0, 0, 1);

        // Randomised traffic.
        for (int i = 0; i < 1500; i++) begin
            cycle(($urandom_range(0, 3) != 0), 4'($urandom), ($urandom_range(0, 2) == 0),
                  1'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0));
        end
        for (int i = 0; i < 20 && q.size() != 0; i++) cycle(1, 4'($urandom), 1, 0, 0, 0, 1);

        // Asynchronous reset after two words of a frame.
        cycle(1, 4'hE, 1, 0, 0, 0, 1);
        cycle(1, 4'h1, 0, 0, 0, 0, 1);
        cycle(1, 4'h3, 0, 0, 0, 0, 1);
        in_valid = 0;
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_zero();
        @(negedge clk);
        reset = 1'b0;
        cycle(1, 4'h0, 1, 0, 0, 0, 1);
        check("post_rst_par", 32'(out_parity8), 0);
        check("post_rst_cnt", 32'(out_count8), 1);
        check("post_rst_valid", 32'(out_valid8), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/stream_parity_accumulator.md
Name: stream_parity_accumulator

Overview:
- Parametrised streaming successor to the 4-input parity K-map cell.
- Reduces each WIDTH-bit input word to a parity bit and accumulates parity across a multi-word frame delimited by in_last.
- Emits one result per frame over a valid/ready handshake: frame parity, word count and optional check error.
- Sits between a packet source and the link-integrity logic; replaces per-word combinational parity cells.

Parameters:
- WIDTH, 4, bits per input word (>=1)
- CNT_W, 8, width of the frame word counter (>=1)
- ODD_DEFAULT, 0, parity mode applied after reset until the first frame samples in_odd (0 = even, 1 = odd)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  input word valid
- in_ready  output  1  block can accept a word this cycle
- in_data  input  WIDTH  input word
- in_last  input  1  word is the final word of its frame
- in_odd  input  1  parity mode, sampled on the first word of a frame
- in_chk_en  input  1  on the last word: compare the result against in_chk
- in_chk  input  1  expected frame parity, valid with in_last
- out_valid  output  1  frame result valid
- out_ready  input  1  consumer accepts the result
- out_parity  output  1  frame parity bit
- out_count  output  CNT_W  words in frame, saturating
- out_ovf  output  1  frame word count saturated
- out_err  output  1  in_chk_en was set and out_parity != in_chk

Behaviour:
- Reset (async assert, sync release):
  - out_valid=0, out_parity=0, out_count=0, out_ovf=0, out_err=0.
  - Accumulator cleared; counter cleared; FSM to IDLE; held mode = ODD_DEFAULT.
- Word parity: p(w) = XOR of all WIDTH bits of in_data. For WIDTH=4 this matches the existing K-map truth table exactly.
- Accept condition: accept = in_valid && in_ready.
  - in_ready = !out_valid || out_ready (combinational).
  - in_ready is independent of in_valid.
- FSM states and transitions:
  - IDLE: no words accumulated. On accept, mode_q <= in_odd.
    - If in_last: publish a 1-word frame; stay in IDLE.
    - Otherwise: acc <= p(w), cnt <= 1, go to ACCUM.
  - ACCUM: on accept, acc <= acc ^ p(w), cnt <= cnt+1 (saturating). in_odd is ignored mid-frame.
    - If in_last: publish and return to IDLE.
- Publish, on the accept edge:
  - out_parity <= acc_next ^ mode_eff, where acc_next includes the current word and mode_eff is in_odd in IDLE or mode_q in ACCUM.
  - out_count <= final count, saturating.
  - out_ovf <= 1 if the count reached 2^CNT_W-1 with at least one further word.
  - out_err <= in_chk_en & (out_parity_next != in_chk).
  - out_valid <= 1.
  - Accumulator and counter cleared in the same edge.
- Latency: result is visible the cycle after the accepted in_last word.
- Output hold: out_* are stable while out_valid && !out_ready.
- Clearing out_valid: out_valid goes to 0 when out_ready=1 and no publish occurs in the same cycle.
- Simultaneous events: out_ready=1 together with an accepted last word gives back-to-back results; out_valid stays 1 and new values load. This sustains a 1-frame-per-cycle throughput.
- Backpressure: while out_valid && !out_ready, in_ready=0. No words are accepted and the accumulator is frozen.
- Saturation: cnt stops at 2^CNT_W-1; parity accumulation continues correctly.
- Reset mid-frame: partial frame discarded; nothing published for it.
- in_chk_en, in_chk and in_data with in_valid=0 have no effect.

Test Plan:
- WIDTH=4, even mode: single word 4'h1 with in_last, in_chk_en=0 -> next cycle out_valid=1, out_parity=1, out_count=1, out_err=0. Sweep all 16 values as 1-word frames; parity is 1 for 1,2,4,7,8,B,D,E.
- Frame 4'h3, 4'h7, 4'h1(last), in_odd=1 on the first word -> out_parity=1 (XOR 0^1^1=0, inverted), out_count=3. Toggling in_odd mid-frame has no effect.
- Check path: frame 4'hF(last), in_chk_en=1, in_chk=1 -> out_parity=0, out_err=1. Repeat with in_chk=0 -> out_err=0.
- Backpressure: hold out_ready=0 with a result pending, offer 4'h2 -> in_ready=0 and outputs stable for 5 cycles. Raise out_ready -> word accepted the same cycle. Back-to-back 1-word frames with out_ready=1 keep out_valid high.
- Saturation, CNT_W=2: 5-word frame of 4'h1 -> out_count=3, out_ovf=1, out_parity=1.
- Reset asserted asynchronously after 2 words of a frame -> outputs zero immediately. A following 1-word frame 4'h0 -> out_parity=0, out_count=1.
